gr_bin_arb: RTL and testbench
=============================

# gr_bin_arb

Round-robin arbiter and sequencer that shares one `gr_bin` Gray-to-binary converter among `N_REQ` requesters. Each requester presents a Gray-coded word with a valid/ready handshake. The block grants one requester per cycle, converts the word, and holds the binary result in a one-entry output register tagged with the requester ID. It sits between the Gray-coded sources (e.g. synchronised CDC pointers, encoder counters) and the single downstream consumer.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `W`, 8: data width in bits.
- `ID_W`, $clog2(N_REQ): width of the requester ID.

- `clk` in 1: the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in N_REQ: per-requester valid.
- `req_data` in N_REQ*W: Gray words; requester i occupies bits [i*W +: W].
- `req_ready` out N_REQ: per-requester accept strobe; one-hot or zero.
- `out_valid` out 1: the output register holds a converted word.
- `out_data` out W: binary result.
- `out_id` out ID_W: index of the requester whose word is held.
- `out_ready` in 1: downstream accepts the output word.
- `busy` out 1: equals `out_valid`.

## Operation
- FSM has two states:
  - EMPTY: no word held. Reset lands here.
  - FULL: a word is held.
- `slot_free` = (state==EMPTY) | `out_ready`.
- Grant:
  - Round-robin search over `req_valid`, starting at pointer `rr_ptr`.
  - The first valid index found is `gnt`.
  - `req_ready[gnt]` = `slot_free`. All other `req_ready` bits are 0.
  - `req_ready` depends combinationally on `req_valid` and `out_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- Accept (`req_valid[gnt]` & `req_ready[gnt]`):
  - `out_data` <= `gr_bin(req_data[gnt])`.
  - `out_id` <= `gnt`.
  - `out_valid` <= 1.
  - `rr_ptr` <= (`gnt`+1) mod `N_REQ`, wrapping from N_REQ-1 to 0.
- Conversion: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. Purely combinational, inside `gr_bin`.
- Drain (FULL & `out_ready`) with no accept in the same cycle: return to EMPTY, `out_valid` <= 0. `out_data` and `out_id` keep their last values.
- Drain and accept in the same cycle: stay FULL and load the new word. There is no bubble.
- FULL & !`out_ready`:
  - `out_data`, `out_id` and `out_valid` are held stable.
  - All `req_ready` bits are 0.
  - `rr_ptr` is unchanged.
- No valid requester: no grant, and `rr_ptr` is unchanged.
- Reset (`rst_n`=0 at a rising edge):
  - Next state is EMPTY; `out_valid`=0, `out_data`=0, `out_id`=0, `rr_ptr`=0.
  - `req_ready` is forced to 0 combinationally while `rst_n`=0.
  - A word pending mid-handshake is discarded.

## Timing
- Latency is 1 cycle: a word accepted at edge k appears on `out_*` after edge k, visible in cycle k+1.
- Throughput is 1 word per cycle while `out_ready`=1.
- Fairness: a continuously valid requester is granted within N_REQ accepts.
- The output register drives `out_*` directly; there is no combinational path from `req_*` to `out_*`.
- Outputs after reset: `out_valid`=0, `out_data`=0, `out_id`=0, `busy`=0, `req_ready`=0 until the first cycle with `rst_n`=1.

## Structure
- Package `gr_bin_pkg` holds:
  - the state enum `{ST_EMPTY, ST_FULL}`;
  - default constants `GB_N_REQ`=4 and `GB_W`=8.
- The existing `gr_bin` module is the single sub-module. Instantiate it once on the muxed `req_data[gnt]`; do not replicate it per requester.
- The round-robin search lives in `gr_bin_arb` as a function over the rotated `req_valid` vector.

## Test plan
- Single word: requester 0 valid with 8'hFF, `out_ready`=1 → `req_ready`=4'b0001; next cycle `out_valid`=1, `out_data`=8'hAA, `out_id`=0; one cycle later `out_valid`=0.
- Full contention: all 4 requesters valid (8'h80, 8'hC0, 8'h03, 8'h01), `out_ready`=1 → grants 0,1,2,3,0,… on consecutive cycles; `out_data` sequence 8'hFF, 8'h80, 8'h02, 8'h01.
- Backpressure: output FULL with `out_id`=2, `out_ready`=0 for 3 cycles → `out_data`/`out_id` stable, `req_ready`=0; on release the next grant goes to 3.
- Pointer wrap: after a grant to 3, requesters 0 and 2 valid → 0 granted, then 2.
- Reset mid-operation: `out_valid`=1 and `rr_ptr`=2, assert `rst_n`=0 for one edge → `out_valid`=0, `out_data`=0, `out_id`=0; the first grant after reset goes to the lowest valid index.
- Exhaustive: requester 1 sweeps Gray 0..255, `out_ready` randomly toggled → every `out_data` matches the reference conversion, `out_id`=1, no word lost or duplicated.

Source files
------------

// File: rtl/gr_bin_pkg.sv
// Shared types and default sizing for the Gray-to-binary arbiter slice.
package gr_bin_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY,
    ST_FULL
  } gb_state_e;

  localparam int GB_N_REQ = 4;
  localparam int GB_W     = 8;

endpackage

// File: rtl/gr_bin_arb_if.sv
// Requester/consumer handshake bundle for gr_bin_arb; slave is the arbiter side.
interface gr_bin_arb_if
  import gr_bin_pkg::*;
#(
  parameter int N_REQ = GB_N_REQ,
  parameter int W     = GB_W
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               out_valid;
  logic [W-1:0]       out_data;
  logic [ID_W-1:0]    out_id;
  logic               out_ready;
  logic               busy;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, busy
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, busy
  );

endinterface

// File: rtl/gr_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gr_bin #(
  parameter int W = 8
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  logic acc;

  always_comb begin
    bin = '0;
    acc = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/gr_bin_arb.sv
// Round-robin arbiter sharing one gr_bin converter among N_REQ requesters,
// with a one-entry tagged output register.
module gr_bin_arb
  import gr_bin_pkg::*;
#(
  parameter int N_REQ = GB_N_REQ,
  parameter int W     = GB_W,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic         clk,
  input  logic         rst_n,
  gr_bin_arb_if.slave  bus
);

  gb_state_e       state;
  logic [ID_W-1:0] rr_ptr;
  logic            valid_q;
  logic [W-1:0]    data_q;
  logic [ID_W-1:0] id_q;

  logic            found;
  logic [ID_W-1:0] gnt;
  logic            slot_free;
  logic            accept;
  logic [W-1:0]    gray_sel;
  logic [W-1:0]    bin_sel;
  logic [N_REQ-1:0] ready;

  function automatic logic [ID_W-1:0] wrap_idx(input int s);
    return (s >= N_REQ) ? ID_W'(s - N_REQ) : ID_W'(s);
  endfunction

  // Rotate so that rr_ptr sits at bit 0, then take the lowest set bit.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                            input logic [ID_W-1:0]  ptr);
    logic [N_REQ-1:0] rot;
    logic [ID_W:0]    res;
    for (int k = 0; k < N_REQ; k++) rot[k] = valid[wrap_idx(int'(ptr) + k)];
    res = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (rot[k] && !res[ID_W]) res = {1'b1, wrap_idx(int'(ptr) + k)};
    end
    return res;
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
    return (int'(g) == N_REQ - 1) ? '0 : g + 1'b1;
  endfunction

  assign {found, gnt} = rr_pick(bus.req_valid, rr_ptr);
  assign slot_free    = (state == ST_EMPTY) || bus.out_ready;
  assign accept       = rst_n && found && slot_free;
  assign gray_sel     = bus.req_data[int'(gnt) * W +: W];

  always_comb begin
    ready = '0;
    if (accept) ready[gnt] = 1'b1;
  end

  gr_bin #(.W(W)) u_conv (
    .gray (gray_sel),
    .bin  (bin_sel)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state   <= ST_FULL;
            valid_q <= 1'b1;
            data_q  <= bin_sel;
            id_q    <= gnt;
            rr_ptr  <= next_ptr(gnt);
          end
        end
        ST_FULL: begin
          // Drain and refill in the same cycle keeps the slot full with no bubble.
          if (accept) begin
            data_q <= bin_sel;
            id_q   <= gnt;
            rr_ptr <= next_ptr(gnt);
          end else if (bus.out_ready) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
  assign bus.busy      = valid_q;

endmodule

// File: tb/tb_gr_bin_arb.sv
// Directed bench for gr_bin_arb: reset, single word, contention, backpressure, wrap, reset mid-run, Gray sweep.
module tb_gr_bin_arb;
  import gr_bin_pkg::*;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  gr_bin_arb_if #(.N_REQ(4), .W(8)) bus ();

  gr_bin_arb #(.N_REQ(4), .W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] ref_bin(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    for (int i = 1; i < 8; i++) b = b ^ (g >> i);
    return b;
  endfunction

  logic [7:0] exp_bin [4];
  int sent;
  int got;

  initial begin
    errs   = 0;
    checks = 0;
    exp_bin = '{8'hFF, 8'h80, 8'h02, 8'h01};
    clk = 1'b0;
    rst_n = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;

    // Reset with every requester valid: nothing may be granted.
    tick();
    chk("reset_ready", 32'(bus.req_ready), 32'h0);
    chk("reset_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_data",  32'(bus.out_data),  32'h0);
    chk("reset_id",    32'(bus.out_id),    32'h0);
    chk("reset_busy",  32'(bus.busy),      32'h0);
    rst_n = 1'b1;
    bus.req_valid = 4'h0;
    tick();

    // Single word from requester 0.
    bus.req_data[7:0] = 8'hFF;
    bus.req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    chk("single_valid", 32'(bus.out_valid), 32'h1);
    chk("single_data",  32'(bus.out_data),  32'hAA);
    chk("single_id",    32'(bus.out_id),    32'h0);
    chk("single_busy",  32'(bus.busy),      32'h1);
    tick();
    chk("single_drain_valid", 32'(bus.out_valid), 32'h0);
    chk("single_drain_hold",  32'(bus.out_data),  32'hAA);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Full contention, continuous out_ready.
    bus.req_data  = {8'h01, 8'h03, 8'hC0, 8'h80};
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk($sformatf("cont_ready_%0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
      tick();
      chk($sformatf("cont_id_%0d", k),   32'(bus.out_id),   32'(k % 4));
      chk($sformatf("cont_data_%0d", k), 32'(bus.out_data), 32'(exp_bin[k % 4]));
    end

    // Backpressure while holding requester 2's word.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_ready_%0d", k), 32'(bus.req_ready), 32'h0);
      tick();
      chk($sformatf("bp_valid_%0d", k), 32'(bus.out_valid), 32'h1);
      chk($sformatf("bp_id_%0d", k),    32'(bus.out_id),    32'h2);
      chk($sformatf("bp_data_%0d", k),  32'(bus.out_data),  32'h02);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'h8);
    tick();
    chk("bp_release_id",   32'(bus.out_id),   32'h3);
    chk("bp_release_data", 32'(bus.out_data), 32'h01);

    // Pointer wrap: after grant 3, requesters 0 and 2 valid.
    bus.req_valid = 4'b0101;
    #1;
    chk("wrap_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    chk("wrap_id0",    32'(bus.out_id),    32'h0);
    chk("wrap_data0",  32'(bus.out_data),  32'hFF);
    chk("wrap_ready2", 32'(bus.req_ready), 32'h4);
    tick();
    chk("wrap_id2",    32'(bus.out_id),    32'h2);
    chk("wrap_data2",  32'(bus.out_data),  32'h02);

    // Grant requester 1 so the pointer sits at 2 with a word held.
    bus.req_valid = 4'b0010;
    tick();
    chk("pre_rst_id",    32'(bus.out_id),    32'h1);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'h1);

    // Reset mid-operation.
    bus.req_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("midrst_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_data",  32'(bus.out_data),  32'h0);
    chk("midrst_id",    32'(bus.out_id),    32'h0);
    chk("midrst_busy",  32'(bus.busy),      32'h0);
    rst_n = 1'b1;
    bus.req_valid = 4'b1010;
    #1;
    chk("postrst_ready", 32'(bus.req_ready), 32'h2);
    tick();
    chk("postrst_id",   32'(bus.out_id),   32'h1);
    chk("postrst_data", 32'(bus.out_data), 32'h80);
    bus.req_valid = 4'b0000;
    tick();
    chk("postrst_drain", 32'(bus.out_valid), 32'h0);

    // Requester 1 sweeps all Gray codes under random backpressure.
    bus.req_data = '0;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 3000 && got < 256; cyc++) begin
      bus.req_valid = (sent < 256) ? 4'b0010 : 4'b0000;
      bus.req_data[15:8] = sent[7:0];
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("sweep_data_%0d", got), 32'(bus.out_data), 32'(ref_bin(got[7:0])));
        chk($sformatf("sweep_id_%0d", got),   32'(bus.out_id),   32'h1);
        got++;
      end
      if (bus.req_ready[1]) sent++;
      tick();
    end
    chk("sweep_count", 32'(got), 32'd256);
    chk("sweep_sent",  32'(sent), 32'd256);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
